rr_mux_4x1: RTL and testbench
=============================

# rr_mux_4x1

Four-lane round-robin multiplexer with valid/ready handshake: the merging counterpart of our 1-to-4 demultiplexer. It collects beats from four independent source lanes and delivers them, one per cycle, onto a single registered output stream tagged with the originating lane index, so a downstream demux can route them back. It sits between per-lane producers and a shared single-lane datapath or link.

## Interface
Parameters:
- DATA_W, 8, width of each lane's data beat

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  4  per-lane beat valid; bit i = lane i
- in_data  in  4*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]
- in_ready  out  4  per-lane accept; at most one bit high per cycle
- out_valid  out  1  registered output beat valid
- out_data  out  DATA_W  registered output beat
- out_sel  out  2  lane index the current output beat came from
- out_ready  in  1  downstream accept

## Operation
- Accept on lane i when in_valid[i] && in_ready[i]. Emit when out_valid && out_ready.
- Output register is "free" when !out_valid || out_ready.
- Round-robin pointer ptr (2 bits) names the highest-priority lane. Priority order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- grant = one-hot of first valid lane in priority order; zero if no lane is valid.
- in_ready = grant & {4{free}}. Combinational from in_valid, ptr and output state. There is no combinational path from in_data.
- On accept from lane g:
  - out_data <= lane g data, out_sel <= g, out_valid <= 1.
  - ptr <= g+1 mod 4; lane 3 wraps to 0.
- If free with no accept, out_valid <= 0. out_data and out_sel hold their last values.
- Sources must hold in_valid and in_data until accepted. A higher-priority lane asserting later may take the grant first; this is legal.
- Idle lanes never block: only valid lanes compete.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0 (lane 0 highest), state ARB. in_ready=0 while rst_n is low.
- Latency: a beat accepted in cycle n is on out_* in cycle n+1.
- Throughput: one beat per cycle with out_ready held high, including back-to-back beats from the same or different lanes.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready=0 and out_* is stable.
- Simultaneous emit and accept in one cycle: the register reloads and out_valid stays 1 with no bubble.
- Reset asserted mid-transfer: outputs return to reset values immediately. Any in-flight beat is dropped, and the pointer and lock state clear.

## Configuration
- RR_MUX_LOCK_EN defined:
  - Adds ports in_last (in, 4) and out_last (out, 1). out_last is registered alongside out_data and resets to 0.
  - State machine ARB/LOCK:
    - ARB -> LOCK on accepting a beat with in_last[g]=0; the locked lane g is stored.
    - In LOCK, grant is forced to the locked lane only; other lanes see in_ready=0 even if valid.
    - LOCK -> ARB on accepting a beat with in_last=1. ptr advances only at that point, to g+1.
  - Packets are never interleaved.
- RR_MUX_LOCK_EN undefined: no in_last/out_last ports and no lock state. Every beat re-arbitrates.

## Structure
- Package rr_mux_pkg:
  - LANES=4 and SEL_W=2.
  - State enum {ARB, LOCK}.
  - Lane-slice helper function for the in_data packing.
- Sub-module rr_arb_4: purely combinational; (req[3:0], ptr[1:0]) -> grant one-hot and grant index. Instantiated once.
- Top level: output register, pointer and lock FSM.

## Test plan
- Reset then single beat: lane 2 drives 0xA5, out_ready=1 -> in_ready=4'b0100 for one cycle; next cycle out_valid=1, out_data=0xA5, out_sel=2; then ptr=3.
- All four lanes valid continuously, out_ready=1, after reset -> out_sel sequence 0,1,2,3,0,… with one beat per cycle.
- Backpressure: out_valid=1 and out_ready=0 for 5 cycles with lanes 1 and 3 valid -> in_ready=0 and out_* stable throughout; on release, lane 1 is served first if ptr<=1.
- Wrap-around: ptr=3 with lanes 0 and 3 valid -> lane 3 granted, then lane 0.
- Reset mid-stream: deassert rst_n while out_valid=1 -> out_valid=0, out_data=0, out_sel=0 asynchronously; after release, lane 0 has priority.
- With RR_MUX_LOCK_EN: lane 1 sends a 3-beat packet (in_last on beat 3) while lane 0 is continuously valid -> out_sel=1,1,1 then 0, and out_last is high only on the third beat.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared constants, lock-state encoding and lane-slice helper for the 4-lane round-robin mux.
// The lock state only takes effect when RR_MUX_LOCK_EN is defined.
package rr_mux_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } rrState_e;

  // Lowest bit of lane `lane` inside a packed {lane3, lane2, lane1, lane0} data bus.
  function automatic int laneLsb(input int lane, input int dataW);
    return lane * dataW;
  endfunction

endpackage

// File: rtl/rr_mux_4x1_if.sv
// Bundle for rr_mux_4x1: four source lanes in, one tagged stream out.
// in_last/out_last exist only when RR_MUX_LOCK_EN is defined.
interface rr_mux_4x1_if
  import rr_mux_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic [LANES-1:0]        in_valid;
  logic [LANES*DATA_W-1:0] in_data;
  logic [LANES-1:0]        in_ready;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;
`ifdef RR_MUX_LOCK_EN
  logic [LANES-1:0]        in_last;
  logic                    out_last;
`endif

  // master: the mux itself; slave: the producers and downstream consumer around it.
`ifdef RR_MUX_LOCK_EN
  modport master (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );
  modport slave (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );
`else
  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
`endif

endinterface

// File: rtl/rr_arb_4.sv
// Combinational 4-way round-robin arbiter: the first requesting lane at or after ptr
// (wrapping mod 4) wins; no request gives an all-zero grant.
module rr_arb_4
  import rr_mux_pkg::*;
(
  input  logic [LANES-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [LANES-1:0] grant,
  output logic [SEL_W-1:0] grantIdx
);

  always_comb begin
    logic             found;
    logic [SEL_W-1:0] lane;
    // NOTE: every output and temporary gets a default before the search so no path
    // leaves them unassigned, which would otherwise infer a latch.
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    lane     = '0;
    for (int k = 0; k < LANES; k++) begin
      lane = ptr + SEL_W'(k);
      if (!found && req[lane]) begin
        found       = 1'b1;
        grant[lane] = 1'b1;
        grantIdx    = lane;
      end
    end
  end

endmodule

// File: rtl/rr_mux_4x1.sv
// Four-lane round-robin merge onto one registered stream tagged with the source lane.
// Define RR_MUX_LOCK_EN to keep a lane granted until it delivers a beat with in_last set.
module rr_mux_4x1
  import rr_mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  rr_mux_4x1_if.master    bus
);

  logic [SEL_W-1:0]  ptr;
  logic              outValid;
  logic [DATA_W-1:0] outData;
  logic [SEL_W-1:0]  outSel;

  logic [LANES-1:0]  req;
  logic [LANES-1:0]  grant;
  logic [SEL_W-1:0]  grantIdx;
  logic              freeSlot;
  logic              accept;
  logic [DATA_W-1:0] laneData;

`ifdef RR_MUX_LOCK_EN
  localparam logic [0:0] stArb  = ARB;
  localparam logic [0:0] stLock = LOCK;

  logic [0:0]       state;
  logic [SEL_W-1:0] lockLane;
  logic             outLast;
  logic             acceptLast;

  // While a packet is open only its own lane may compete.
  assign req        = (state == stLock) ? (bus.in_valid & (LANES'(1) << lockLane)) : bus.in_valid;
  assign acceptLast = bus.in_last[grantIdx];
`else
  assign req = bus.in_valid;
`endif

  rr_arb_4 uArb (
    .req      (req),
    .ptr      (ptr),
    .grant    (grant),
    .grantIdx (grantIdx)
  );

  // in_ready depends only on valids, pointer/lock and output occupancy, never on in_data.
  assign freeSlot     = !outValid || bus.out_ready;
  assign bus.in_ready = grant & {LANES{freeSlot && rst_n}};
  assign accept       = |bus.in_ready;
  assign laneData     = bus.in_data[laneLsb(int'(grantIdx), DATA_W) +: DATA_W];

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid <= 1'b0;
      outData  <= '0;
      outSel   <= '0;
    end else if (accept) begin
      outValid <= 1'b1;
      outData  <= laneData;
      outSel   <= grantIdx;
    end else if (freeSlot) begin
      outValid <= 1'b0;
    end
  end

`ifdef RR_MUX_LOCK_EN
  // The pointer only moves when a packet closes, so the next packet starts after that lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      state    <= stArb;
      lockLane <= '0;
      outLast  <= 1'b0;
    end else if (accept) begin
      outLast <= acceptLast;
      if (acceptLast) begin
        state <= stArb;
        ptr   <= grantIdx + SEL_W'(1);
      end else begin
        state    <= stLock;
        lockLane <= grantIdx;
      end
    end
  end

  assign bus.out_last = outLast;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= grantIdx + SEL_W'(1);
    end
  end
`endif

  assign bus.out_valid = outValid;
  assign bus.out_data  = outData;
  assign bus.out_sel   = outSel;

endmodule

// File: tb/tb_rr_mux_4x1.sv
// Scoreboard bench for rr_mux_4x1: a reference arbiter predicts grants, expected beats
// are queued on acceptance and compared when the DUT emits them.
module tb_rr_mux_4x1;
  import rr_mux_pkg::*;

  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    sel;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_mux_4x1_if #(.DATA_W(DW)) bus ();

  rr_mux_4x1 #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checkCount = 0;
  int errorCount = 0;

  beat_t         sb[$];
  logic [DW-1:0] srcData[4][$];
  logic          srcLast[4][$];
  logic [1:0]    selLog[$];

  logic [1:0] mPtr;
  logic       mOutValid;
  logic       mLocked;
  logic [1:0] mLockLane;
  int         readyMode;
  int         emitCount;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPtr      = 2'd0;
    mOutValid = 1'b0;
    mLocked   = 1'b0;
    mLockLane = 2'd0;
  endtask

  task automatic pushBeat(input int lane, input logic [DW-1:0] data, input logic last);
    srcData[lane].push_back(data);
    srcLast[lane].push_back(last);
  endtask

  task automatic driveInputs();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid[i]        = (srcData[i].size() > 0);
      bus.in_data[i*DW +: DW] = (srcData[i].size() > 0) ? srcData[i][0] : '0;
`ifdef RR_MUX_LOCK_EN
      bus.in_last[i]         = (srcLast[i].size() > 0) ? srcLast[i][0] : 1'b0;
`endif
    end
    case (readyMode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Reference arbiter: rotate the valid vector so the pointer lane sits at bit 0.
  function automatic logic [3:0] modelGrant();
    logic [7:0] dbl;
    if (mLocked) return bus.in_valid & (4'b0001 << mLockLane);
    dbl = {bus.in_valid, bus.in_valid} >> mPtr;
    for (int k = 0; k < 4; k++)
      if (dbl[k]) return 4'b0001 << 2'(int'(mPtr) + k);
    return 4'b0000;
  endfunction

  function automatic int pending();
    int n = sb.size() + int'(mOutValid);
    for (int i = 0; i < 4; i++) n += srcData[i].size();
    return n;
  endfunction

  // One clock: check at the falling edge, advance model and sources just after the rising edge.
  task automatic cycle();
    logic [3:0] expGrant;
    logic [3:0] accMask;
    logic       mFree;
    int         g;
    beat_t      exp;
    @(negedge clk);
    mFree    = !mOutValid || bus.out_ready;
    expGrant = mFree ? modelGrant() : 4'b0000;
    check("in_ready", 32'(bus.in_ready), 32'(expGrant));
    check("out_valid", 32'(bus.out_valid), 32'(mOutValid));
    if (bus.out_valid && bus.out_ready) begin
      emitCount++;
      selLog.push_back(bus.out_sel);
      if (sb.size() == 0) begin
        check("spurious beat", 32'(bus.out_valid), 32'd0);
      end else begin
        exp = sb.pop_front();
        check("out_data", 32'(bus.out_data), 32'(exp.data));
        check("out_sel", 32'(bus.out_sel), 32'(exp.sel));
`ifdef RR_MUX_LOCK_EN
        check("out_last", 32'(bus.out_last), 32'(exp.last));
`endif
      end
    end
    g = -1;
    for (int k = 0; k < 4; k++) if (expGrant[k]) g = k;
    if (g >= 0) begin
      exp.data = srcData[g][0];
      exp.sel  = 2'(g);
      exp.last = srcLast[g][0];
      sb.push_back(exp);
    end
    accMask = bus.in_valid & bus.in_ready;
    @(posedge clk);
    #1;
    if (g >= 0) begin
      mOutValid = 1'b1;
`ifdef RR_MUX_LOCK_EN
      if (!mLocked) begin
        if (exp.last) mPtr = 2'(g + 1);
        else begin
          mLocked   = 1'b1;
          mLockLane = 2'(g);
        end
      end else if (exp.last) begin
        mLocked = 1'b0;
        mPtr    = 2'(g + 1);
      end
`else
      mPtr = 2'(g + 1);
`endif
    end else if (mFree) begin
      mOutValid = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (accMask[i] && srcData[i].size() > 0) begin
        void'(srcData[i].pop_front());
        void'(srcLast[i].pop_front());
      end
    end
    driveInputs();
  endtask

  task automatic drain(input int maxCycles);
    int n = 0;
    while (pending() > 0 && n < maxCycles) begin
      if (mLocked && srcData[mLockLane].size() == 0) begin
        pushBeat(int'(mLockLane), 8'($urandom_range(1, 255)), 1'b1);
        driveInputs();
      end
      cycle();
      n++;
    end
    check("drain pending", 32'(pending()), 32'd0);
  endtask

  initial begin
    logic [1:0] lockOrder [4];
    logic       lastBit;

    modelReset();
    readyMode     = 0;
    emitCount     = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 4'b0100;
    bus.in_data   = '0;
    bus.in_data[2*DW +: DW] = 8'hA5;
    bus.out_ready = 1'b1;
`ifdef RR_MUX_LOCK_EN
    bus.in_last   = 4'b1111;
`endif

    // Reset state, including in_ready gated low while a lane is already valid.
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_data", 32'(bus.out_data), 32'd0);
    check("rst out_sel", 32'(bus.out_sel), 32'd0);
    check("rst in_ready", 32'(bus.in_ready), 32'd0);
`ifdef RR_MUX_LOCK_EN
    check("rst out_last", 32'(bus.out_last), 32'd0);
`endif
    rst_n = 1'b1;
    readyMode = 1;
    driveInputs();

    // Single beat from lane 2.
    pushBeat(2, 8'hA5, 1'b1);
    driveInputs();
    cycle();
    check("single out_valid", 32'(bus.out_valid), 32'd1);
    check("single out_data", 32'(bus.out_data), 32'hA5);
    check("single out_sel", 32'(bus.out_sel), 32'd2);
    drain(20);

    // Pointer now at 3: lane 3 beats lane 0, then lane 0 follows.
    pushBeat(0, 8'h11, 1'b1);
    pushBeat(3, 8'h33, 1'b1);
    driveInputs();
    cycle();
    check("wrap first sel", 32'(bus.out_sel), 32'd3);
    cycle();
    check("wrap second sel", 32'(bus.out_sel), 32'd0);
    drain(20);

    // Backpressure: output full and stalled for 5 cycles with lanes 1 and 3 waiting.
    readyMode = 0;
    pushBeat(0, 8'h40, 1'b1);
    driveInputs();
    cycle();
    pushBeat(1, 8'h51, 1'b1);
    pushBeat(3, 8'h73, 1'b1);
    driveInputs();
    repeat (5) begin
      cycle();
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
      check("bp out_data", 32'(bus.out_data), 32'h40);
      check("bp out_sel", 32'(bus.out_sel), 32'd0);
    end
    readyMode = 1;
    driveInputs();
    selLog.delete();
    drain(40);
    check("bp release order lane1", 32'(selLog.size() > 1 ? selLog[1] : 2'd0), 32'd1);

    // Reset in the middle of a busy stream.
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 6; k++) pushBeat(l, 8'(16 * (l + 1) + k + 1), 1'b1);
    driveInputs();
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst out_data", 32'(bus.out_data), 32'd0);
    check("midrst out_sel", 32'(bus.out_sel), 32'd0);
    check("midrst in_ready", 32'(bus.in_ready), 32'd0);
    sb.delete();
    for (int l = 0; l < 4; l++) begin
      srcData[l].delete();
      srcLast[l].delete();
    end
    modelReset();
    driveInputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All lanes continuously valid: one beat per cycle in lane order 0,1,2,3,...
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 6; k++) pushBeat(l, 8'(16 * (l + 1) + k + 8), 1'b1);
    driveInputs();
    selLog.delete();
    emitCount = 0;
    repeat (24) cycle();
    check("throughput beats", 32'(emitCount), 32'd23);
    for (int k = 0; k < 8; k++)
      check("rr sel order", 32'(selLog[k]), 32'(k % 4));
    drain(40);

    // Random traffic with random downstream stalls.
    readyMode = 2;
    for (int c = 0; c < 400; c++) begin
      cycle();
      if ($urandom_range(0, 2) == 0) begin
`ifdef RR_MUX_LOCK_EN
        lastBit = ($urandom_range(0, 2) != 0);
`else
        lastBit = 1'b1;
`endif
        pushBeat(int'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), lastBit);
        driveInputs();
      end
    end
    drain(3000);
    readyMode = 1;
    driveInputs();

`ifdef RR_MUX_LOCK_EN
    // Lane 1 packet of 3 beats must not be interleaved with a continuously valid lane 0.
    lockOrder = '{2'd1, 2'd1, 2'd1, 2'd0};
    pushBeat(1, 8'hB1, 1'b0);
    driveInputs();
    selLog.delete();
    cycle();
    pushBeat(1, 8'hB2, 1'b0);
    pushBeat(1, 8'hB3, 1'b1);
    for (int k = 0; k < 4; k++) pushBeat(0, 8'(8'hC0 + k), 1'b1);
    driveInputs();
    drain(40);
    for (int k = 0; k < 4; k++)
      check("lock sel order", 32'(selLog.size() > k ? selLog[k] : 2'd3), 32'(lockOrder[k]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
